// File: rtl/spi_rx_pkg.sv
// Shared types, constants and helpers for the SPI sample receiver.
package spi_rx_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } rx_state_e;

    localparam int unsigned SyncDepth          = 2;
    localparam int unsigned DefaultWordW       = 12;
    localparam int unsigned DefaultIdleTimeout = 64;

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
    function automatic bit sample_on_rise(input bit cpol, input bit cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// Multi-flop synchronizer for asynchronous SPI pins, with a configurable reset value.
module spi_rx_sync
    import spi_rx_pkg::*;
#(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [SyncDepth-1:0][Width-1:0] stage_q;

    // Shift the pin value through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= {SyncDepth{ResetVal}};
        end else begin
            stage_q <= {stage_q[SyncDepth-2:0], d_i};
        end
    end

    assign q_o = stage_q[SyncDepth-1];

endmodule

// File: rtl/spi_sample_receiver.sv
// SPI slave receiver: oversamples SCLK/MOSI/CS_n, deserialises MSB-first words and
// presents them on a valid/ready interface with overrun and framing-error status.
// WORD_W must be at least 2.
module spi_sample_receiver
    import spi_rx_pkg::*;
#(
    parameter int unsigned WORD_W       = DefaultWordW,
    parameter bit          CPOL         = 1'b0,
    parameter bit          CPHA         = 1'b0,
    parameter bit          USE_CS       = 1'b1,
    parameter int unsigned IDLE_TIMEOUT = DefaultIdleTimeout
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk_i,
    input  logic              spi_mosi_i,
    input  logic              spi_cs_n_i,
    input  logic              rx_ready_i,
    input  logic              clr_overrun_i,
    output logic [WORD_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              overrun_o,
    output logic              frame_err_o,
    output logic              busy_o,
    output logic [15:0]       word_cnt_o
);

    localparam int unsigned     CntW       = $clog2(WORD_W + 1);
    localparam logic [CntW-1:0] LastBit    = CntW'(WORD_W - 1);
    localparam logic [15:0]     IdleLast   = 16'(IDLE_TIMEOUT - 1);
    localparam bit              SampleRise = sample_on_rise(CPOL, CPHA);

    logic sclk_s, mosi_s, cs_n_s;
    logic sclk_prev_q;
    logic edge_rise, edge_fall, sample_edge, cs_active;

    spi_rx_sync #(
        .Width    (1),
        .ResetVal (CPOL)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (spi_sclk_i),
        .q_o   (sclk_s)
    );

    spi_rx_sync #(
        .Width    (1),
        .ResetVal (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (spi_mosi_i),
        .q_o   (mosi_s)
    );

    spi_rx_sync #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_sync_cs_n (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (spi_cs_n_i),
        .q_o   (cs_n_s)
    );

    // Third sclk flop, used only for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_prev_q <= CPOL;
        end else begin
            sclk_prev_q <= sclk_s;
        end
    end

    assign edge_rise   = sclk_s & ~sclk_prev_q;
    assign edge_fall   = ~sclk_s & sclk_prev_q;
    assign sample_edge = SampleRise ? edge_rise : edge_fall;
    assign cs_active   = !USE_CS || !cs_n_s;

    rx_state_e         state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0] shreg_q, shreg_d;
    logic [15:0]       idle_cnt_q, idle_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic              word_done;
    logic [WORD_W-1:0] word_next;

    // Deserialiser FSM: shift on sample edges, finish on the last bit, abort on cs loss/timeout.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        idle_cnt_d  = idle_cnt_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        word_next   = {shreg_q, mosi_s};
        unique case (state_q)
            StIdle: begin
                idle_cnt_d = '0;
                if (sample_edge && cs_active) begin
                    shreg_d   = word_next[WORD_W-2:0];
                    bit_cnt_d = CntW'(1);
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (sample_edge && (bit_cnt_q == LastBit)) begin
                    // The final bit wins over a cs release seen in the same cycle.
                    word_done  = 1'b1;
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                    state_d    = StIdle;
                end else if (!cs_active || (!sample_edge && (idle_cnt_q == IdleLast))) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    idle_cnt_d  = '0;
                    state_d     = StIdle;
                end else if (sample_edge) begin
                    shreg_d    = word_next[WORD_W-2:0];
                    bit_cnt_d  = bit_cnt_q + CntW'(1);
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              handshake, load;

    assign handshake = rx_valid_q & rx_ready_i;
    assign load      = word_done & (~rx_valid_q | rx_ready_i);

    // Holding register: load a finished word if the slot is free or being drained, else drop it.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        word_cnt_d = word_cnt_q;
        if (handshake) begin
            rx_valid_d = 1'b0;
            word_cnt_d = word_cnt_q + 16'd1;
        end
        if (load) begin
            rx_data_d  = word_next;
            rx_valid_d = 1'b1;
        end
        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
        if (word_done && !load) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            idle_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            idle_cnt_q  <= idle_cnt_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q == StShift);
    assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_spi_sample_receiver.sv
// Directed bench for spi_sample_receiver.
// DUT 0: mode 0 with CS; DUT 1: mode 0 without CS; DUT 2: mode 3; DUT 3: mode 2 on DUT 2's pins.
module tb_spi_sample_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] sclk_v, mosi_v, csn_v;
    logic [3:0] ready_v, clr_v;

    logic [3:0][11:0] data;
    logic [3:0][15:0] cnt;
    logic [3:0]       valid, ovr, fe, busy;

    int errors = 0;
    int checks = 0;

    int          fe_cnt [4];
    int          vcyc   [4];
    int          acc    [4];
    logic [11:0] last   [4];

    always #5 clk = ~clk;

    spi_sample_receiver #(.WORD_W(12), .CPOL(1'b0), .CPHA(1'b0), .USE_CS(1'b1), .IDLE_TIMEOUT(64))
    u_m0 (
        .clk(clk), .rst_n(rst_n), .spi_sclk_i(sclk_v[0]), .spi_mosi_i(mosi_v[0]),
        .spi_cs_n_i(csn_v[0]), .rx_ready_i(ready_v[0]), .clr_overrun_i(clr_v[0]),
        .rx_data_o(data[0]), .rx_valid_o(valid[0]), .overrun_o(ovr[0]), .frame_err_o(fe[0]),
        .busy_o(busy[0]), .word_cnt_o(cnt[0])
    );

    spi_sample_receiver #(.WORD_W(12), .CPOL(1'b0), .CPHA(1'b0), .USE_CS(1'b0), .IDLE_TIMEOUT(64))
    u_nocs (
        .clk(clk), .rst_n(rst_n), .spi_sclk_i(sclk_v[1]), .spi_mosi_i(mosi_v[1]),
        .spi_cs_n_i(csn_v[1]), .rx_ready_i(ready_v[1]), .clr_overrun_i(clr_v[1]),
        .rx_data_o(data[1]), .rx_valid_o(valid[1]), .overrun_o(ovr[1]), .frame_err_o(fe[1]),
        .busy_o(busy[1]), .word_cnt_o(cnt[1])
    );

    spi_sample_receiver #(.WORD_W(12), .CPOL(1'b1), .CPHA(1'b1), .USE_CS(1'b1), .IDLE_TIMEOUT(64))
    u_m3 (
        .clk(clk), .rst_n(rst_n), .spi_sclk_i(sclk_v[2]), .spi_mosi_i(mosi_v[2]),
        .spi_cs_n_i(csn_v[2]), .rx_ready_i(ready_v[2]), .clr_overrun_i(clr_v[2]),
        .rx_data_o(data[2]), .rx_valid_o(valid[2]), .overrun_o(ovr[2]), .frame_err_o(fe[2]),
        .busy_o(busy[2]), .word_cnt_o(cnt[2])
    );

    spi_sample_receiver #(.WORD_W(12), .CPOL(1'b1), .CPHA(1'b0), .USE_CS(1'b1), .IDLE_TIMEOUT(64))
    u_m2x (
        .clk(clk), .rst_n(rst_n), .spi_sclk_i(sclk_v[2]), .spi_mosi_i(mosi_v[2]),
        .spi_cs_n_i(csn_v[2]), .rx_ready_i(ready_v[3]), .clr_overrun_i(clr_v[3]),
        .rx_data_o(data[3]), .rx_valid_o(valid[3]), .overrun_o(ovr[3]), .frame_err_o(fe[3]),
        .busy_o(busy[3]), .word_cnt_o(cnt[3])
    );

    // Mid-cycle monitor: frame_err pulses, valid cycles and accepted words per DUT.
    initial begin
        for (int k = 0; k < 4; k++) begin
            fe_cnt[k] = 0;
            vcyc[k]   = 0;
            acc[k]    = 0;
            last[k]   = 12'h000;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (fe[k]) fe_cnt[k]++;
                if (valid[k]) vcyc[k]++;
                if (valid[k] && ready_v[k]) begin
                    last[k] = data[k];
                    acc[k]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        sclk_v  = 3'b100;
        mosi_v  = 3'b000;
        csn_v   = 3'b111;
        ready_v = 4'b0000;
        clr_v   = 4'b0000;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Master model: data changes 2 clk after the falling edge, SCLK period 8 clk.
    task automatic spi_send(input int s, input logic [11:0] w, input int n, input logic cpol);
        for (int i = 0; i < n; i++) begin
            sclk_v[s] = 1'b0;
            repeat (2) @(negedge clk);
            mosi_v[s] = w[11-i];
            repeat (2) @(negedge clk);
            sclk_v[s] = 1'b1;
            repeat (4) @(negedge clk);
            if (!cpol) sclk_v[s] = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (data[0] !== 12'h000) begin errors++; $display("FAIL reset_data: got %h want 000", data[0]); end
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid[0]); end
        checks++;
        if (ovr[0] !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ovr[0]); end
        checks++;
        if (fe[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", fe[0]); end
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
        checks++;
        if (cnt[0] !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h want 0000", cnt[0]); end
    endtask

    task automatic test_single_word();
        int fe_s, v_s, a_s;
        do_reset();
        fe_s = fe_cnt[0]; v_s = vcyc[0]; a_s = acc[0];
        ready_v[0] = 1'b1;
        csn_v[0]   = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 12'hA5C, 12, 1'b0);
        repeat (8) @(negedge clk);
        csn_v[0] = 1'b1;
        checks++;
        if (last[0] !== 12'hA5C) begin errors++; $display("FAIL single_data: got %h want a5c", last[0]); end
        checks++;
        if (acc[0] - a_s !== 1) begin errors++; $display("FAIL single_accepts: got %0d want 1", acc[0] - a_s); end
        checks++;
        if (vcyc[0] - v_s !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", vcyc[0] - v_s); end
        checks++;
        if (cnt[0] !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", cnt[0]); end
        checks++;
        if (fe_cnt[0] - fe_s !== 0) begin errors++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt[0] - fe_s); end
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b want 0", valid[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        csn_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 12'h001, 12, 1'b0);
        checks++;
        if (valid[0] !== 1'b1 || data[0] !== 12'h001) begin
            errors++; $display("FAIL b2b_first: got v=%b d=%h want v=1 d=001", valid[0], data[0]);
        end
        checks++;
        if (ovr[0] !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun_yet: got %b want 0", ovr[0]); end
        spi_send(0, 12'h800, 12, 1'b0);
        checks++;
        if (ovr[0] !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", ovr[0]); end
        spi_send(0, 12'hFFF, 12, 1'b0);
        checks++;
        if (data[0] !== 12'h001) begin errors++; $display("FAIL b2b_hold: got %h want 001", data[0]); end
        ready_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (last[0] !== 12'h001) begin errors++; $display("FAIL b2b_accepted: got %h want 001", last[0]); end
        checks++;
        if (cnt[0] !== 16'd1) begin errors++; $display("FAIL b2b_cnt: got %0d want 1", cnt[0]); end
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL b2b_valid_clear: got %b want 0", valid[0]); end
        checks++;
        if (ovr[0] !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky: got %b want 1", ovr[0]); end
        clr_v[0] = 1'b1;
        @(negedge clk);
        clr_v[0] = 1'b0;
        checks++;
        if (ovr[0] !== 1'b0) begin errors++; $display("FAIL b2b_clr_overrun: got %b want 0", ovr[0]); end
        csn_v[0] = 1'b1;
    endtask

    task automatic test_cs_abort();
        int fe_s, a_s;
        do_reset();
        fe_s = fe_cnt[0]; a_s = acc[0];
        ready_v[0] = 1'b1;
        csn_v[0]   = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 12'h3C3, 7, 1'b0);
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b want 1", busy[0]); end
        csn_v[0] = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (fe_cnt[0] - fe_s !== 1) begin errors++; $display("FAIL abort_frame_err: got %0d want 1", fe_cnt[0] - fe_s); end
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", busy[0]); end
        checks++;
        if (acc[0] - a_s !== 0) begin errors++; $display("FAIL abort_no_word: got %0d want 0", acc[0] - a_s); end
        csn_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 12'h3C3, 12, 1'b0);
        repeat (4) @(negedge clk);
        csn_v[0] = 1'b1;
        checks++;
        if (last[0] !== 12'h3C3) begin errors++; $display("FAIL abort_next_data: got %h want 3c3", last[0]); end
        checks++;
        if (cnt[0] !== 16'd1) begin errors++; $display("FAIL abort_next_cnt: got %0d want 1", cnt[0]); end
        checks++;
        if (fe_cnt[0] - fe_s !== 1) begin errors++; $display("FAIL abort_one_pulse: got %0d want 1", fe_cnt[0] - fe_s); end
    endtask

    task automatic test_idle_timeout();
        int fe_s;
        do_reset();
        fe_s = fe_cnt[1];
        ready_v[1] = 1'b1;
        // csn stays high: this instance must ignore it.
        spi_send(1, 12'hFFF, 5, 1'b0);
        repeat (56) @(negedge clk);
        checks++;
        if (fe_cnt[1] - fe_s !== 0 || busy[1] !== 1'b1) begin
            errors++; $display("FAIL timeout_early: got fe=%0d busy=%b want fe=0 busy=1", fe_cnt[1] - fe_s, busy[1]);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (fe[1] !== 1'b0) begin errors++; $display("FAIL timeout_before_edge: got %b want 0", fe[1]); end
        @(negedge clk);
        checks++;
        if (fe[1] !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b want 1", fe[1]); end
        repeat (3) @(negedge clk);
        checks++;
        if (fe_cnt[1] - fe_s !== 1) begin errors++; $display("FAIL timeout_pulse_count: got %0d want 1", fe_cnt[1] - fe_s); end
        checks++;
        if (busy[1] !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy[1]); end
        spi_send(1, 12'h123, 12, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (last[1] !== 12'h123) begin errors++; $display("FAIL timeout_next_data: got %h want 123", last[1]); end
        checks++;
        if (cnt[1] !== 16'd1) begin errors++; $display("FAIL timeout_next_cnt: got %0d want 1", cnt[1]); end
    endtask

    task automatic test_polarity();
        do_reset();
        ready_v[2] = 1'b1;
        ready_v[3] = 1'b1;
        csn_v[2]   = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(2, 12'h5A5, 12, 1'b1);
        repeat (6) @(negedge clk);
        csn_v[2] = 1'b1;
        checks++;
        if (last[2] !== 12'h5A5) begin errors++; $display("FAIL mode3_data: got %h want 5a5", last[2]); end
        checks++;
        if (cnt[2] !== 16'd1) begin errors++; $display("FAIL mode3_cnt: got %0d want 1", cnt[2]); end
        // Wrong-phase decoder samples each bit before it changes: one-bit lag.
        checks++;
        if (last[3] !== 12'h2D2) begin errors++; $display("FAIL wrong_phase_data: got %h want 2d2", last[3]); end
        checks++;
        if (last[3] === 12'h5A5) begin errors++; $display("FAIL wrong_phase_differs: got %h want not 5a5", last[3]); end
    endtask

    task automatic test_reset_mid_word();
        int fe_s;
        do_reset();
        fe_s = fe_cnt[0];
        ready_v[0] = 1'b1;
        csn_v[0]   = 1'b0;
        repeat (4) @(negedge clk);
        spi_send(0, 12'h7E1, 6, 1'b0);
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy[0]); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || valid[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got busy=%b valid=%b want 0 0", busy[0], valid[0]);
        end
        checks++;
        if (data[0] !== 12'h000 || cnt[0] !== 16'd0 || ovr[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got d=%h c=%0d o=%b want 000 0 0", data[0], cnt[0], ovr[0]);
        end
        repeat (4) @(negedge clk);
        spi_send(0, 12'h7E1, 12, 1'b0);
        repeat (4) @(negedge clk);
        csn_v[0] = 1'b1;
        checks++;
        if (last[0] !== 12'h7E1) begin errors++; $display("FAIL rstmid_next_data: got %h want 7e1", last[0]); end
        checks++;
        if (cnt[0] !== 16'd1) begin errors++; $display("FAIL rstmid_next_cnt: got %0d want 1", cnt[0]); end
        checks++;
        if (fe_cnt[0] - fe_s !== 0) begin errors++; $display("FAIL rstmid_frame_err: got %0d want 0", fe_cnt[0] - fe_s); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_cs_abort();
        test_idle_timeout();
        test_polarity();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
